dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (DMEM).
- Port 0 is the core load/store unit; port 1 is the auxiliary master (debug/loader).
- Accepts one request at a time, drives the DMEM command for exactly one access cycle, then returns read data or completion to the owner.
- Checks alignment and select encodings before any access is issued.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  port 0 request, held until granted
m0_gnt  out  1  port 0 grant, one-cycle pulse, combinational in IDLE
m0_addr  in  ADDR_WIDTH  port 0 byte address
m0_wdata  in  DATA_WIDTH  port 0 write data
m0_we  in  1  port 0: 1 = write, 0 = read
m0_wsel  in  2  port 0 write size: 00 word, 01 byte, 10 half
m0_rsel  in  3  port 0 read type: 000 lw, 001 lb, 010 lh, 101 lbu, 110 lhu
m0_rvalid  out  1  port 0 response pulse
m0_rdata  out  DATA_WIDTH  port 0 read data, valid with m0_rvalid
m0_err  out  1  port 0 error flag, valid with m0_rvalid
m1_*  same set as m0_*, for port 1
mem_addr  out  ADDR_WIDTH  to DMEM Addr
mem_dataw  out  DATA_WIDTH  to DMEM DataW
mem_wsel  out  2  to DMEM WSel
mem_rsel  out  3  to DMEM RSel
mem_memrw  out  1  to DMEM MemRW (1 = write)
mem_datar  in  DATA_WIDTH  from DMEM DataR

Behaviour:
- Reset is asynchronous, active-low, on rst_n; it is the single clock domain on clk.
- Reset values:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All gnt, rvalid and err outputs = 0; all rdata outputs = 0.
  - All mem_* outputs = 0; mem_memrw = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, assert gnt to the winner.
  - Winner selection: the only requester; or, when both request, the port not equal to last_grant (round-robin).
  - On the rising edge with gnt high: latch addr, wdata, we, wsel and rsel into the command register, set owner and last_grant to the winner, evaluate err, and go to ACCESS.
  - No request: stay in IDLE.
- err rule: err = (addr[1:0] != 0) OR (we AND wsel == 11) OR (not we AND rsel not in {000, 001, 010, 101, 110}).
- ACCESS (1 cycle):
  - mem_addr, mem_dataw, mem_wsel and mem_rsel are driven from the command register.
  - mem_memrw = we AND NOT err.
  - DMEM commits the write or updates DataR at the closing edge.
  - Next state: RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1 and err = latched err.
  - rdata = mem_datar for an error-free read; 0 for writes and errors.
  - mem_memrw = 0; mem_addr is held.
  - No gnt is issued in RESP. Next state: IDLE.
- Timing: gnt to rvalid is 2 cycles; best-case throughput is one transaction per 3 cycles.
- mem_memrw is 1 only in ACCESS, so a write never repeats. Reads in IDLE/RESP only refresh DataR and are harmless.
- After gnt, the requester may drop or change its inputs; the latched command is used.
- A req that deasserts before gnt is not served.
- The non-owner's rvalid and gnt stay 0 throughout the transaction.
- rst_n asserted in ACCESS or RESP: abort immediately, no rvalid, state = IDLE. A write whose ACCESS closing edge has not yet occurred is not performed.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Enabled:
  - Adds input ports m0_lock and m1_lock (1 bit), sampled with the command at gnt.
  - A granted transaction with lock = 1 sets locked_owner. While it is set, IDLE grants only that port and the other port's req is ignored.
  - The lock is cleared when the owner is granted with lock = 0, or by reset.
  - This supports atomic read-modify-write sequences.
- Disabled: the lock ports do not exist; pure round-robin.

Test Plan:
1. Reset, then m0 writes addr 0x10, data 0xDEADBEEF, wsel 00; then m0 reads 0x10 rsel 000 -> write: mem_memrw = 1 for exactly one cycle; read: m0_rvalid 2 cycles after gnt with rdata 0xDEADBEEF, err 0.
2. m0 and m1 request continuously from reset, both reading -> grants alternate m0, m1, m0, m1; each rvalid goes only to its owner.
3. Word 0x000080F0 at 0x20; reads rsel 001 and 101 -> 0xFFFFFFF0 and 0x000000F0; then write byte 0xAB with wsel 01 -> reading the word returns 0x000080AB.
4. m1 writes addr 0x22, and separately reads with rsel 011 -> m1_err = 1 with rvalid; mem_memrw stays 0; memory is unchanged.
5. rst_n dropped during ACCESS of an m0 write to 0x30 -> no rvalid; outputs go to reset values; a following read of 0x30 returns the old value.
6. DMEM_ARB_LOCK_EN: m0 accepted with lock = 1 while m1 requests -> m1 is starved until m0 is accepted with lock = 0; m1 is granted next.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port DMEM: round-robin grant, one access cycle, one response cycle.
// Optional DMEM_ARB_LOCK_EN adds m0_lock/m1_lock so one port can hold the memory across several transactions.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  output logic                  m0_gnt,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_we,
  input  logic [1:0]            m0_wsel,
  input  logic [2:0]            m0_rsel,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  output logic                  m1_gnt,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_we,
  input  logic [1:0]            m1_wsel,
  input  logic [2:0]            m1_rsel,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dataw,
  output logic [1:0]            mem_wsel,
  output logic [2:0]            mem_rsel,
  output logic                  mem_memrw,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  input  logic [DATA_WIDTH-1:0] mem_datar
);

  // state  | meaning
  // IDLE   | grant a requester combinationally, latch its command
  // ACCESS | drive the latched command to DMEM for one cycle
  // RESP   | return rvalid/rdata/err to the owner
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic                  r_last_grant, r_owner, r_we, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_wsel;
  logic [2:0]            r_rsel;

  logic                  w_req0, w_req1, w_any, w_win, w_gnt, w_err, w_we, w_rsel_ok;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata, w_rdata;
  logic [1:0]            w_wsel;
  logic [2:0]            w_rsel;

`ifdef DMEM_ARB_LOCK_EN
  logic r_locked, r_lock_owner, w_lock;
`endif

  always_comb begin
    w_req0 = m0_req;
    w_req1 = m1_req;
`ifdef DMEM_ARB_LOCK_EN
    // while locked, the other port is masked out entirely
    if (r_locked) begin
      w_req0 = m0_req & ~r_lock_owner;
      w_req1 = m1_req & r_lock_owner;
    end
    w_lock = w_win ? m1_lock : m0_lock;
`endif
    w_any = w_req0 | w_req1;
    w_win = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
    w_gnt = (r_state == S_IDLE) && w_any;

    w_addr  = w_win ? m1_addr  : m0_addr;
    w_wdata = w_win ? m1_wdata : m0_wdata;
    w_we    = w_win ? m1_we    : m0_we;
    w_wsel  = w_win ? m1_wsel  : m0_wsel;
    w_rsel  = w_win ? m1_rsel  : m0_rsel;

    case (w_rsel)
      3'b000, 3'b001, 3'b010, 3'b101, 3'b110: w_rsel_ok = 1'b1;
      default:                                w_rsel_ok = 1'b0;
    endcase
    w_err = (w_addr[1:0] != 2'b00) | (w_we & (w_wsel == 2'b11)) | (~w_we & ~w_rsel_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wsel       <= '0;
      r_rsel       <= '0;
`ifdef DMEM_ARB_LOCK_EN
      r_locked     <= 1'b0;
      r_lock_owner <= 1'b0;
`endif
    end else if (w_gnt) begin
      r_last_grant <= w_win;
      r_owner      <= w_win;
      r_we         <= w_we;
      r_err        <= w_err;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_wsel       <= w_wsel;
      r_rsel       <= w_rsel;
`ifdef DMEM_ARB_LOCK_EN
      r_locked     <= w_lock;
      r_lock_owner <= w_win;
`endif
    end
  end

  assign mem_addr  = r_addr;
  assign mem_dataw = r_wdata;
  assign mem_wsel  = r_wsel;
  assign mem_rsel  = r_rsel;
  assign w_rdata   = (r_we | r_err) ? '0 : mem_datar;

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_memrw = 1'b0;
    case (r_state)
      S_IDLE: begin
        m0_gnt = w_gnt & ~w_win;
        m1_gnt = w_gnt & w_win;
      end
      S_ACCESS: mem_memrw = r_we & ~r_err;
      S_RESP: begin
        if (r_owner) begin
          m1_rvalid = 1'b1;
          m1_err    = r_err;
          m1_rdata  = w_rdata;
        end else begin
          m0_rvalid = 1'b1;
          m0_err    = r_err;
          m0_rdata  = w_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
